// File: rtl/mult_fifo_pkg.sv
// Shared widths and types for the multiplier result FIFO.
package mult_fifo_pkg;

    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned ACC_W      = 12;

    typedef logic [DATA_W_DEF-1:0] product_t;
    typedef logic [ACC_W-1:0]      acc_t;

endpackage

// File: rtl/mult_fifo_mem.sv
// Register-array storage for the result FIFO: one write port, one combinational read port.
module mult_fifo_mem
    import mult_fifo_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Contents are intentionally left unreset; validity is tracked by the FIFO count.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/mult_result_fifo.sv
// Small FIFO buffering multiplier products, with optional running sum of popped results.
// Optional feature: define RESULT_ACCUM_EN to enable the 12-bit acc_out accumulator.
module mult_result_fifo
    import mult_fifo_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst,
    input  logic                     in_valid,
    input  logic [DATA_W-1:0]        in_data,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    input  logic                     out_ready,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count,
    output acc_t                     acc_out
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count_q;
    logic          push;
    logic          pop;

    // Handshake flags depend only on registered occupancy.
    assign in_ready  = (count_q != CW'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign count     = count_q;

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CW'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

    mult_fifo_mem #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .AW     (AW)
    ) u_mem (
        .clk   (sys_clk),
        .we    (push && !flush),
        .waddr (wr_ptr),
        .wdata (in_data),
        .raddr (rd_ptr),
        .rdata (out_data)
    );

`ifdef RESULT_ACCUM_EN
    acc_t acc_q;

    // Running sum of popped products, wrapping modulo 2^ACC_W.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            acc_q <= '0;
        end else if (flush) begin
            acc_q <= '0;
        end else if (pop) begin
            acc_q <= acc_q + ACC_W'(out_data);
        end
    end

    assign acc_out = acc_q;
`else
    assign acc_out = '0;
`endif

endmodule

// File: tb/tb_mult_result_fifo.sv
// Scoreboard bench for mult_result_fifo: directed stimulus, queue-based reference, negedge monitor.
module tb_mult_result_fifo;

    localparam int DEPTH = 4;

    logic        sys_clk;
    logic        sys_rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready;
    logic        flush;
    logic [2:0]  count;
    logic [11:0] acc_out;

    int          vectors;
    int          miscompares;
    logic [7:0]  exp_q [$];
    logic [11:0] acc_m;
    logic [7:0]  fill_a [4];

    mult_result_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (8)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .flush     (flush),
        .count     (count),
        .acc_out   (acc_out)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic r, input logic f);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
        step();
    endtask

    // Reference model: pops/pushes decided from the model occupancy, compared at negedge.
    always @(negedge sys_clk) begin
        logic do_pop;
        logic do_push;
        if (sys_rst) begin
            exp_q.delete();
            acc_m = '0;
        end else begin
            check("count", int'(count), exp_q.size());
            check("out_valid", int'(out_valid), int'(exp_q.size() != 0));
            check("in_ready", int'(in_ready), int'(exp_q.size() != DEPTH));
            check("acc_out", int'(acc_out), int'(acc_m));
            if (flush) begin
                exp_q.delete();
                acc_m = '0;
            end else begin
                do_pop  = out_ready && (exp_q.size() != 0);
                do_push = in_valid && (exp_q.size() < DEPTH);
                if (do_pop) begin
                    check("pop_data", int'(out_data), int'(exp_q[0]));
`ifdef RESULT_ACCUM_EN
                    acc_m = acc_m + 12'(exp_q[0]);
`endif
                    void'(exp_q.pop_front());
                end
                if (do_push) begin
                    exp_q.push_back(in_data);
                end
            end
        end
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        acc_m       = '0;
        sys_rst     = 1'b1;
        in_valid    = 1'b0;
        in_data     = '0;
        out_ready   = 1'b0;
        flush       = 1'b0;
        fill_a[0] = 8'h0F; fill_a[1] = 8'h31; fill_a[2] = 8'hE1; fill_a[3] = 8'h00;

        // Reset then idle
        repeat (2) step();
        check("rst_count", int'(count), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_acc", int'(acc_out), 0);
        sys_rst = 1'b0;
        repeat (2) step();
        check("idle_count", int'(count), 0);
        check("idle_out_valid", int'(out_valid), 0);

        // Fill to full, refused fifth push, drain in order
        for (int i = 0; i < 4; i++) drive(1'b1, fill_a[i], 1'b0, 1'b0);
        check("full_count", int'(count), 4);
        check("full_in_ready", int'(in_ready), 0);
        drive(1'b1, 8'h12, 1'b0, 1'b0);
        check("refused_count", int'(count), 4);
        for (int i = 0; i < 4; i++) drive(1'b0, 8'h00, 1'b1, 1'b0);
        check("drained_count", int'(count), 0);

        // Full with push and pop together: pop only, then push next cycle
        for (int i = 0; i < 4; i++) drive(1'b1, 8'(8'h11 * (i + 1)), 1'b0, 1'b0);
        drive(1'b1, 8'h55, 1'b1, 1'b0);
        check("full_pushpop_count", int'(count), 3);
        drive(1'b1, 8'h55, 1'b0, 1'b0);
        check("late_push_count", int'(count), 4);
        for (int i = 0; i < 4; i++) drive(1'b0, 8'h00, 1'b1, 1'b0);

        // Steady push+pop at count=2 across pointer wrap
        drive(1'b1, 8'hA1, 1'b0, 1'b0);
        drive(1'b1, 8'hA2, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 8'(8'hB0 + i), 1'b1, 1'b0);
            check("stream_count", int'(count), 2);
        end
        for (int i = 0; i < 2; i++) drive(1'b0, 8'h00, 1'b1, 1'b0);

        // Flush beats concurrent push and pop
        drive(1'b1, 8'hC1, 1'b0, 1'b0);
        drive(1'b1, 8'hC2, 1'b0, 1'b0);
        drive(1'b1, 8'hC3, 1'b1, 1'b0);
        drive(1'b1, 8'hC4, 1'b0, 1'b0);
        check("preflush_count", int'(count), 3);
        drive(1'b1, 8'hC5, 1'b1, 1'b1);
        check("flush_count", int'(count), 0);
        check("flush_out_valid", int'(out_valid), 0);
        check("flush_acc", int'(acc_out), 0);
        drive(1'b0, 8'h00, 1'b0, 1'b0);

        // Accumulate twenty pops of 0xE1
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 8'hE1, 1'b0, 1'b0);
            drive(1'b0, 8'h00, 1'b1, 1'b0);
        end
`ifdef RESULT_ACCUM_EN
        check("acc_20x_e1", int'(acc_out), 404);
`else
        check("acc_disabled", int'(acc_out), 0);
`endif

        // Reset asserted mid-transfer
        drive(1'b1, 8'h77, 1'b0, 1'b0);
        drive(1'b1, 8'h78, 1'b0, 1'b0);
        in_valid = 1'b0;
        #2 sys_rst = 1'b1;
        #1;
        check("async_rst_count", int'(count), 0);
        check("async_rst_out_valid", int'(out_valid), 0);
        check("async_rst_in_ready", int'(in_ready), 1);
        check("async_rst_acc", int'(acc_out), 0);
        step();
        sys_rst = 1'b0;
        step();
        check("post_rst_count", int'(count), 0);
        drive(1'b1, 8'h99, 1'b0, 1'b0);
        check("post_rst_push_count", int'(count), 1);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        check("final_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
